// File: rtl/imem_boot_ctrl.sv
// Boot/run sequencer: assembles a host byte stream into LE words, writes imem from word 0, then releases the core.
// Latency: one word is written on the cycle after its 4th byte is accepted; ECALL stalls the core combinationally and halts it on the next cycle.
// Backpressure: byte_ready is high only in LOAD, so bytes offered outside a load are ignored.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   start, load_len   - load/restart request; word count (0 = run existing image, clamped to DEPTH)
//   byte_in/valid/ready - loader byte stream with valid/ready handshake
//   mem_we/waddr/wdata  - instruction memory write port (one pulse per word)
//   fetch_instr       - instruction currently presented to the core
//   cpu_hold, cpu_pc_rst, halted - core control and status
//   words_loaded      - words written by the current or last load
module imem_boot_ctrl #(
    parameter int          ADDR_W     = 6,
    parameter int          DEPTH      = 64,
    parameter logic [31:0] ECALL_WORD = 32'h0000_0073
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       fetch_instr,
    output logic              cpu_hold,
    output logic              cpu_pc_rst,
    output logic              halted,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] len_q;
    logic [1:0]      byte_idx;
    logic [23:0]     asm_q;       // lower three bytes of the word being assembled
    logic [ADDR_W:0] wl_inc;
    logic            start_ok;
    logic            load_accept;
    logic            take_byte;
    logic            is_ecall;
    logic            last_word;

    assign is_ecall    = (fetch_instr == ECALL_WORD);
    assign wl_inc      = words_loaded + CNT_ONE;
    assign last_word   = (wl_inc == len_q);
    // start only counts when the controller is not mid-load
    assign start_ok    = start && (state == S_IDLE || state == S_RUN || state == S_HALT);
    assign load_accept = start_ok && (load_len != '0);
    assign take_byte   = byte_valid && (state == S_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        cpu_hold   = 1'b1;
        cpu_pc_rst = 1'b1;
        halted     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (load_len != '0) ? S_LOAD : S_RUN;
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                if (byte_valid && byte_idx == 2'd3 && last_word) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                cpu_pc_rst = 1'b0;
                // freeze the PC on the ECALL itself, same cycle it is fetched
                cpu_hold   = is_ecall;
                if (start) state_nxt = (load_len != '0) ? S_LOAD : S_RUN;
                else if (is_ecall) state_nxt = S_HALT;
            end
            S_HALT: begin
                cpu_pc_rst = 1'b0;
                halted     = 1'b1;
                if (start) state_nxt = (load_len != '0) ? S_LOAD : S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q        <= '0;
            byte_idx     <= '0;
            asm_q        <= '0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            if (load_accept) begin
                len_q        <= (load_len > DEPTH_W) ? DEPTH_W : load_len;
                byte_idx     <= '0;
                words_loaded <= '0;
            end else if (take_byte) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: asm_q[7:0]   <= byte_in;
                    2'd1: asm_q[15:8]  <= byte_in;
                    2'd2: asm_q[23:16] <= byte_in;
                    default: begin
                        // words_loaded doubles as the write pointer; len <= DEPTH keeps it in range
                        mem_we       <= 1'b1;
                        mem_waddr    <= words_loaded[ADDR_W-1:0];
                        mem_wdata    <= {byte_in, asm_q};
                        words_loaded <= wl_inc;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: table-driven vectors plus directed multi-cycle sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: byte_ready sampled before each offered byte in the long-load sequence.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  load_len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] fetch_instr;
    logic        cpu_hold;
    logic        cpu_pc_rst;
    logic        halted;
    logic [6:0]  words_loaded;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    imem_boot_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .load_len     (load_len),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .fetch_instr  (fetch_instr),
        .cpu_hold     (cpu_hold),
        .cpu_pc_rst   (cpu_pc_rst),
        .halted       (halted),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic [6:0]  len;
        logic        bv;
        logic [7:0]  b;
        logic [31:0] fetch;
        logic        br;
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic        hold;
        logic        pcr;
        logic        halt;
        logic [6:0]  wl;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic s, input logic [6:0] len,
                                input logic bv, input logic [7:0] b, input logic [31:0] f,
                                input logic br, input logic we, input logic [5:0] wa,
                                input logic [31:0] wd, input logic hold, input logic pcr,
                                input logic halt, input logic [6:0] wl);
        vec_t v;
        v.rst = r; v.start = s; v.len = len; v.bv = bv; v.b = b; v.fetch = f;
        v.br = br; v.we = we; v.wa = wa; v.wd = wd;
        v.hold = hold; v.pcr = pcr; v.halt = halt; v.wl = wl;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".byte_ready"},   32'(byte_ready),   32'(v.br));
        chk({tag, ".mem_we"},       32'(mem_we),       32'(v.we));
        chk({tag, ".mem_waddr"},    32'(mem_waddr),    32'(v.wa));
        chk({tag, ".mem_wdata"},    mem_wdata,         v.wd);
        chk({tag, ".cpu_hold"},     32'(cpu_hold),     32'(v.hold));
        chk({tag, ".cpu_pc_rst"},   32'(cpu_pc_rst),   32'(v.pcr));
        chk({tag, ".halted"},       32'(halted),       32'(v.halt));
        chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(v.wl));
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            rst         = tbl[i].rst;
            start       = tbl[i].start;
            load_len    = tbl[i].len;
            byte_valid  = tbl[i].bv;
            byte_in     = tbl[i].b;
            fetch_instr = tbl[i].fetch;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i]);
        end
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   seg_a;
        int   nwr;
        int   bad_wr;
        int   ready_miss;
        logic [31:0] exp_w;
        logic [31:0] got_data;
        logic [5:0]  got_addr;
        vec_t rv;

        // Segment A: load two words (ADDI-like 0x13, then ECALL), DONE, RUN.
        //   r  s  len bv  b      fetch    br we wa  wd            hd pr ht wl
        add(0, 1, 2, 0, 8'h00, 32'h0, 1, 0, 0, 32'h0,        1, 1, 0, 0);
        add(0, 0, 0, 1, 8'h13, 32'h0, 1, 0, 0, 32'h0,        1, 1, 0, 0);
        add(0, 0, 0, 1, 8'h00, 32'h0, 1, 0, 0, 32'h0,        1, 1, 0, 0);
        add(0, 0, 0, 1, 8'h00, 32'h0, 1, 0, 0, 32'h0,        1, 1, 0, 0);
        add(0, 0, 0, 1, 8'h00, 32'h0, 1, 1, 0, 32'h13,       1, 1, 0, 1);
        add(0, 0, 0, 1, 8'h73, 32'h0, 1, 0, 0, 32'h13,       1, 1, 0, 1);
        add(0, 0, 0, 1, 8'h00, 32'h0, 1, 0, 0, 32'h13,       1, 1, 0, 1);
        add(0, 0, 0, 1, 8'h00, 32'h0, 1, 0, 0, 32'h13,       1, 1, 0, 1);
        add(0, 0, 0, 1, 8'h00, 32'h0, 0, 1, 1, 32'h73,       1, 1, 0, 2);
        add(0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 1, 32'h73,       0, 0, 0, 2);
        add(0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 1, 32'h73,       0, 0, 0, 2);
        seg_a = tbl.size();
        // Segment B: from HALT restart with len 0, then a len-1 load with gapped valid,
        // then start+ECALL together in RUN (start wins).
        add(0, 1, 0, 0, 8'h00, 32'h0, 0, 0, 1, 32'h73,       0, 0, 0, 2);
        add(0, 1, 1, 0, 8'h00, 32'h0, 1, 0, 1, 32'h73,       1, 1, 0, 0);
        add(0, 0, 0, 1, 8'hAA, 32'h0, 1, 0, 1, 32'h73,       1, 1, 0, 0);
        add(0, 0, 0, 0, 8'hFF, 32'h0, 1, 0, 1, 32'h73,       1, 1, 0, 0);
        add(0, 0, 0, 1, 8'hBB, 32'h0, 1, 0, 1, 32'h73,       1, 1, 0, 0);
        add(0, 0, 0, 0, 8'hEE, 32'h0, 1, 0, 1, 32'h73,       1, 1, 0, 0);
        add(0, 0, 0, 1, 8'hCC, 32'h0, 1, 0, 1, 32'h73,       1, 1, 0, 0);
        add(0, 0, 0, 0, 8'h55, 32'h0, 1, 0, 1, 32'h73,       1, 1, 0, 0);
        add(0, 0, 0, 1, 8'hDD, 32'h0, 0, 1, 0, 32'hDDCCBBAA, 1, 1, 0, 1);
        add(0, 0, 0, 1, 8'h11, 32'h0, 0, 0, 0, 32'hDDCCBBAA, 0, 0, 0, 1);
        add(0, 1, 0, 0, 8'h00, 32'h73, 0, 0, 0, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 32'hDDCCBBAA, 0, 0, 0, 1);

        // Reset state
        rst = 1'b1; start = 1'b0; load_len = '0; byte_in = '0; byte_valid = 1'b0;
        fetch_instr = '0;
        tick();
        tick();
        rv = '{rst:1, start:0, len:0, bv:0, b:0, fetch:0, br:0, we:0, wa:0, wd:0,
               hold:1, pcr:1, halt:0, wl:0};
        chk_all("reset", rv);
        rst = 1'b0;

        run_tbl(0, seg_a);

        // ECALL in RUN: hold rises combinationally, halt registers on the next edge
        fetch_instr = 32'h0000_0073;
        #1;
        chk("ecall_hold_same_cycle", 32'(cpu_hold), 32'd1);
        chk("ecall_not_halted_yet", 32'(halted), 32'd0);
        tick();
        chk("ecall_halted", 32'(halted), 32'd1);
        fetch_instr = 32'h0;
        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!halted || !cpu_hold || cpu_pc_rst || mem_we) nwr++;
        end
        chk("halt_persist_bad_cycles", 32'(nwr), 32'd0);

        run_tbl(seg_a, tbl.size());

        // Clamp: load_len=100 with 256 bytes offered -> exactly 64 words
        start = 1'b1; load_len = 7'd100;
        tick();
        start = 1'b0;
        chk("clamp_ready_start", 32'(byte_ready), 32'd1);
        nwr = 0; bad_wr = 0; ready_miss = 0;
        for (int i = 0; i < 256; i++) begin
            byte_in = i[7:0];
            byte_valid = 1'b1;
            #1;
            if (!byte_ready) ready_miss++;
            tick();
            if (mem_we) begin
                exp_w = {8'(4*nwr+3), 8'(4*nwr+2), 8'(4*nwr+1), 8'(4*nwr)};
                if (mem_waddr !== 6'(nwr) || mem_wdata !== exp_w) bad_wr++;
                nwr++;
            end
        end
        chk("clamp_ready_after", 32'(byte_ready), 32'd0);
        chk("clamp_words_loaded", 32'(words_loaded), 32'd64);
        byte_in = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_we) nwr++;
        end
        byte_valid = 1'b0;
        chk("clamp_write_count", 32'(nwr), 32'd64);
        chk("clamp_bad_writes", 32'(bad_wr), 32'd0);
        chk("clamp_ready_misses", 32'(ready_miss), 32'd0);

        // Reset after 6 bytes of a 3-word load
        start = 1'b1; load_len = 7'd3;
        tick();
        start = 1'b0;
        nwr = 0; got_addr = '1; got_data = '0;
        for (int i = 1; i <= 6; i++) begin
            byte_in = 8'(i);
            byte_valid = 1'b1;
            tick();
            if (mem_we) begin
                nwr++;
                got_addr = mem_waddr;
                got_data = mem_wdata;
            end
        end
        rst = 1'b1; byte_in = 8'h07;
        tick();
        rv = '{rst:1, start:0, len:0, bv:1, b:7, fetch:0, br:0, we:0, wa:0, wd:0,
               hold:1, pcr:1, halt:0, wl:0};
        chk_all("midload_rst", rv);
        byte_in = 8'h08;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            byte_in = 8'(8 + i);
            tick();
            if (mem_we) nwr++;
            if (byte_ready) nwr += 100;
        end
        byte_valid = 1'b0;
        chk("midload_write_count", 32'(nwr), 32'd1);
        chk("midload_addr", 32'(got_addr), 32'd0);
        chk("midload_data", got_data, 32'h04030201);
        chk("midload_idle_hold", 32'(cpu_hold), 32'd1);
        chk("midload_idle_pcrst", 32'(cpu_pc_rst), 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Boot/run sequencer for the 64x32 instruction memory of the RISC-V core.
- Accepts a byte stream from a host loader and assembles it into little-endian 32-bit words. Writes them sequentially into the memory write port from word 0.
- Holds the core in stall/PC-reset while loading, then releases it.
- Watches the fetched instruction and halts the core on ECALL (32'h00000073); halt persists until a reload or reset.

Parameters:
- ADDR_W, 6, instruction memory word-address width.
- DEPTH, 64, number of words; load length is clamped to DEPTH.
- ECALL_WORD, 32'h00000073, instruction encoding that triggers halt.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load (or reload).
- load_len  in  ADDR_W+1  number of words to load; sampled only on accepted start.
- byte_in  in  8  loader data byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  controller accepts byte this cycle.
- mem_we  out  1  instruction memory write enable (one-cycle pulse per word).
- mem_waddr  out  ADDR_W  write word address.
- mem_wdata  out  32  write data.
- fetch_instr  in  32  instruction currently output by instruction memory to the core.
- cpu_hold  out  1  stall the core (PC and pipeline frozen).
- cpu_pc_rst  out  1  force core PC to 0.
- halted  out  1  core stopped on ECALL.
- words_loaded  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- States: IDLE, LOAD, DONE, RUN, HALT.
- Reset:
  - state=IDLE; byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, halted=0, words_loaded=0, byte index=0.
  - cpu_hold=1, cpu_pc_rst=1.
- IDLE:
  - byte_ready=0; cpu_hold=1; cpu_pc_rst=1.
  - start with load_len>0: latch len=min(load_len,DEPTH), word_ptr=0, byte_idx=0, words_loaded=0; go to LOAD.
  - start with load_len==0: go to RUN directly (existing contents run).
- LOAD:
  - byte_ready=1; cpu_hold=1; cpu_pc_rst=1.
  - Each handshake (byte_valid & byte_ready) stores byte_in into bits [8*byte_idx+7 : 8*byte_idx] of the assembly register, then byte_idx++ mod 4.
  - On the 4th byte, the next cycle has mem_we=1, mem_waddr=word_ptr, mem_wdata=assembled word; word_ptr++ and words_loaded++ in the same edge. Byte intake continues without bubble.
  - If that word is the len-th word, go to DONE on the same edge; byte_ready=0 from then on.
  - start is ignored in LOAD and DONE. byte_valid without ready is ignored.
- DONE:
  - Exactly one cycle; the final mem_we is visible here; cpu_hold=1, cpu_pc_rst=1.
  - Then go to RUN.
- RUN:
  - cpu_pc_rst=0.
  - cpu_hold is combinational (fetch_instr==ECALL_WORD), so the PC freezes on the ECALL address.
  - On that condition the next state is HALT and halted becomes 1.
  - start in RUN: same as IDLE start (reload or restart); takes priority over ECALL.
- HALT:
  - cpu_hold=1, halted=1, cpu_pc_rst=0 (PC remains at ECALL).
  - start re-enters LOAD or RUN per load_len and clears halted.
- rst at any point, including mid-word or mid-load:
  - Returns to IDLE; partial word discarded; no mem_we in the following cycle; memory contents already written are untouched.
- mem_waddr never exceeds DEPTH-1; word_ptr does not wrap during a load because len≤DEPTH.
- mem_we is never high in IDLE, RUN or HALT.

Test Plan:
- Reset then start, load_len=2, bytes 13 00 00 00 73 00 00 00 -> two mem_we pulses: addr0=32'h00000013, addr1=32'h00000073. DONE for one cycle, then RUN with cpu_pc_rst=0.
- RUN with fetch_instr=32'h00000073 -> cpu_hold=1 in the same cycle, halted=1 next cycle, stays HALT for ≥10 cycles.
- load_len=100 with 256 bytes offered -> exactly 64 writes (addresses 0..63), words_loaded=64, byte_ready=0 after the 256th byte.
- rst asserted after 6 bytes of load_len=3 -> one write only (addr0), IDLE, no further mem_we, cpu_hold=1.
- From HALT, start with load_len=0 -> RUN, halted=0, cpu_pc_rst=0 next cycle, no writes.
- byte_valid toggled every other cycle during load_len=1 -> single write of the correctly ordered word, with no byte lost or duplicated.
